// File: rtl/hash_uart_tx.sv
// Serialises a right-aligned digest of d bits as ceil(d/8) 8N1 UART frames, MSB byte first.
// Latency: TxD start bit two cycles after transmit rises; frames are 10 bit times plus one idle cycle.
// Backpressure: none; transmit edges while a sequence is in flight, or in the done cycle, are dropped.
// Ports: clk, reset (async active-low), transmit (level, rising edge starts), d (digest bits),
//        data (digest, bit 0 = LSB), TxD (serial line, idle high), busy (sequence in flight),
//        done (one-cycle pulse at sequence end).
module hash_uart_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_W       = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              transmit,
  input  logic [15:0]       d,
  input  logic [DATA_W-1:0] data,
  output logic              TxD,
  output logic              busy,
  output logic              done
);

  localparam int MAX_BYTES = DATA_W / 8;
  localparam int BYTE_W    = $clog2(MAX_BYTES) + 1;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [BYTE_W-1:0] BYTE_ONE = BYTE_W'(1);
  localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]   nbytes_q, nbytes_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;

  // transmit synchroniser and edge history. The _vld flags mark that each
  // register holds a genuine post-reset sample, so a level already high when
  // reset releases is not mistaken for a rising edge.
  logic sync_q, prev_q, sync_vld_q, prev_vld_q;

  logic              edge_det;
  logic              accept;
  logic              bit_end;
  logic [BYTE_W-1:0] nb_in;
  logic [BYTE_W-1:0] byte_idx;
  logic [7:0]        cur_byte;

  assign edge_det = sync_q & ~prev_q & prev_vld_q;
  assign accept   = edge_det & (state_q == IDLE) & ~done_q;
  assign bit_end  = (cnt_q == CNT_MAX);

  // ceil(d/8), clamped to the bus width. Overflow of d+7 only occurs for d
  // far above DATA_W, where the clamp branch is taken anyway.
  assign nb_in = (d > 16'(DATA_W)) ? BYTE_MAX : BYTE_W'((d + 16'd7) >> 3);

  // Byte k of the sequence sits at byte position nbytes-1-k of the latched word.
  assign byte_idx = nbytes_q - byte_cnt_q - BYTE_ONE;
  assign cur_byte = 8'(data_q >> {byte_idx, 3'b000});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    nbytes_d   = nbytes_q;
    data_d     = data_q;
    tx_d       = 1'b1;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          data_d     = data;
          nbytes_d   = nb_in;
          byte_cnt_d = '0;
          bit_d      = '0;
          if (nb_in != '0) begin
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = cur_byte[0];
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_q];
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d    = NEXT;
          cnt_d      = '0;
          byte_cnt_d = byte_cnt_q + BYTE_ONE;
        end
      end
      NEXT: begin
        cnt_d = '0;
        if (byte_cnt_q < nbytes_q) begin
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      nbytes_q   <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      sync_vld_q <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      nbytes_q   <= nbytes_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      sync_q     <= transmit;
      prev_q     <= sync_q;
      sync_vld_q <= 1'b1;
      prev_vld_q <= sync_vld_q;
    end
  end

  assign TxD  = tx_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_hash_uart_tx.sv
module tb_hash_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int SLOT  = FRAME + 1;

  logic         clk;
  logic         reset;
  logic         transmit;
  logic [15:0]  d;
  logic [511:0] data;
  logic         TxD;
  logic         busy;
  logic         done;

  int errors;
  int checks;

  hash_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(512)) dut (
    .clk      (clk),
    .reset    (reset),
    .transmit (transmit),
    .d        (d),
    .data     (data),
    .TxD      (TxD),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line monitor: UART receiver sampling every cycle, plus done/busy counters.
  int          cyc;
  int          done_cnt;
  int          busy_cnt;
  int          frame_bad;
  bit          rx_active;
  int          rx_cnt;
  logic [3:0]  bi;
  logic [9:0]  rx_bits;
  logic [7:0]  rx_q[$];
  logic [9:0]  raw_q[$];
  int          starts[$];

  initial begin
    cyc = 0; done_cnt = 0; busy_cnt = 0; frame_bad = 0;
    rx_active = 0; rx_cnt = 0; rx_bits = '0; bi = '0;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset !== 1'b1) begin
      rx_active = 0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && busy !== 1'b0) frame_bad++;
      if (!rx_active) begin
        if (TxD === 1'b0) begin
          rx_active  = 1;
          rx_cnt     = 0;
          rx_bits[0] = 1'b0;
          starts.push_back(cyc);
        end else if (TxD !== 1'b1) begin
          frame_bad++;
        end
      end else begin
        rx_cnt++;
        bi = 4'(rx_cnt / CPB);
        if (rx_cnt % CPB == 0) rx_bits[bi] = TxD;
        else if (TxD !== rx_bits[bi]) frame_bad++;
      end
      if (rx_active) begin
        if (busy !== 1'b1) frame_bad++;
        if (rx_cnt == FRAME - 1) begin
          if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) frame_bad++;
          rx_q.push_back(rx_bits[8:1]);
          raw_q.push_back(rx_bits);
          rx_active = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference: ceil(d/8) clamped to 64 bytes; byte k is data[8*(n-k)-1 -: 8].
  function automatic int exp_n(input int dl);
    if (dl > 512) return 64;
    return (dl + 7) / 8;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [511:0] dat, input int n, input int k);
    logic [511:0] s;
    s = dat >> (8 * (n - 1 - k));
    return s[7:0];
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    raw_q.delete();
    starts.delete();
  endtask

  // One pulse, optional input scrambling after the latch, full check of the sequence.
  task automatic run_seq(input logic [511:0] dat, input logic [15:0] dl, input bit scramble,
                         input string tag);
    int n, t_done, dc0, bc0, fb0;
    n = exp_n(int'(dl));
    clear_mon();
    dc0 = done_cnt; bc0 = busy_cnt; fb0 = frame_bad;
    data = dat; d = dl; transmit = 1'b1;
    t_done = -1;
    for (int c = 1; c <= 3000 && t_done < 0; c++) begin
      tick();
      if (c == 2) transmit = 1'b0;
      if (scramble && c == 4) begin
        data = rand512();
        d    = 16'($urandom_range(0, 700));
      end
      if (done === 1'b1) t_done = c;
    end
    transmit = 1'b0;
    repeat (3) tick();
    chk({tag, "_done_time"}, t_done, 2 + SLOT * n);
    chk({tag, "_done_cnt"}, done_cnt - dc0, 1);
    chk({tag, "_busy_cycles"}, busy_cnt - bc0, SLOT * n);
    chk({tag, "_frame_bad"}, frame_bad - fb0, 0);
    chk({tag, "_nframes"}, rx_q.size(), n);
    for (int k = 0; k < n && k < rx_q.size(); k++)
      chk({tag, "_byte"}, rx_q[k], exp_byte(dat, n, k));
    for (int k = 1; k < starts.size(); k++)
      chk({tag, "_gap"}, starts[k] - starts[k-1], SLOT);
  endtask

  logic [511:0] dat;
  int dc0, bc0;

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; transmit = 1'b0; d = '0; data = '0;
    repeat (3) tick();
    chk("rst_txd", TxD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    repeat (5) tick();

    // Latency, three-byte sequence and exact bit order of the first frame.
    clear_mon();
    dc0 = done_cnt;
    data = 512'hABCDE; d = 16'd20; transmit = 1'b1;
    tick();
    chk("lat_c1_txd", TxD, 1);
    tick();
    chk("lat_c2_txd", TxD, 0);
    transmit = 1'b0;
    repeat (200) tick();
    chk("d20_nframes", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("d20_b0", rx_q[0], 8'h0A);
      chk("d20_b1", rx_q[1], 8'hBC);
      chk("d20_b2", rx_q[2], 8'hDE);
      chk("d20_bits0", raw_q[0], 10'b1000010100);
    end
    chk("d20_done_cnt", done_cnt - dc0, 1);

    // Full-width digest, byte i = i.
    for (int i = 0; i < 64; i++) dat[8*i +: 8] = 8'(i);
    run_seq(dat, 16'd512, 1'b0, "d512");
    if (rx_q.size() == 64) begin
      chk("d512_first", rx_q[0], 8'h3F);
      chk("d512_last", rx_q[63], 8'h00);
    end

    run_seq(rand512(), 16'd0, 1'b0, "d0");
    run_seq(rand512(), 16'd600, 1'b1, "d600");
    for (int t = 0; t < 4; t++)
      run_seq(rand512(), 16'($urandom_range(1, 600)), 1'b1, "rand");

    // Level held high for 1000 cycles yields one frame.
    clear_mon();
    dc0 = done_cnt;
    dat = rand512(); data = dat; d = 16'd8; transmit = 1'b1;
    repeat (1000) tick();
    transmit = 1'b0;
    repeat (20) tick();
    chk("hold_nframes", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("hold_byte", rx_q[0], exp_byte(dat, 1, 0));
    chk("hold_done_cnt", done_cnt - dc0, 1);

    // Second pulse while busy is dropped.
    clear_mon();
    dc0 = done_cnt;
    dat = rand512(); data = dat; d = 16'd16; transmit = 1'b1;
    repeat (2) tick();
    transmit = 1'b0;
    repeat (28) tick();
    transmit = 1'b1;
    repeat (3) tick();
    transmit = 1'b0;
    repeat (200) tick();
    chk("busy_pulse_nframes", rx_q.size(), 2);
    chk("busy_pulse_done_cnt", done_cnt - dc0, 1);

    // Edge landing in the done cycle is dropped.
    clear_mon();
    dc0 = done_cnt;
    data = rand512(); d = 16'd8; transmit = 1'b1;
    repeat (2) tick();
    transmit = 1'b0;
    repeat (40) tick();
    transmit = 1'b1;
    tick();
    chk("done_edge_done", done, 1);
    repeat (100) tick();
    transmit = 1'b0;
    repeat (5) tick();
    chk("done_edge_nframes", rx_q.size(), 1);
    chk("done_edge_done_cnt", done_cnt - dc0, 1);
    chk("done_edge_busy", busy, 0);

    // Reset during the data bits of the second of three bytes (that byte is 0x00).
    clear_mon();
    dat = 512'hA5003C; data = dat; d = 16'd24; transmit = 1'b1;
    repeat (2) tick();
    transmit = 1'b0;
    repeat (61) tick();
    chk("pre_rst_txd", TxD, 0);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_txd", TxD, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (3) tick();
    clear_mon();
    bc0 = busy_cnt;
    reset = 1'b1;
    repeat (20) tick();
    chk("post_rst_frames", starts.size(), 0);
    chk("post_rst_busy", busy_cnt - bc0, 0);
    run_seq(dat, 16'd24, 1'b0, "restart");

    // Transmit already high when reset releases.
    reset = 1'b0; transmit = 1'b1; d = 16'd16;
    repeat (3) tick();
    clear_mon();
    bc0 = busy_cnt;
    reset = 1'b1;
    repeat (50) tick();
    chk("hi_at_rel_frames", starts.size(), 0);
    chk("hi_at_rel_busy", busy_cnt - bc0, 0);
    transmit = 1'b0;
    repeat (3) tick();
    run_seq(rand512(), 16'd16, 1'b0, "after_hi");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hash_uart_tx.md
HASH_UART_TX -- requirements
Module: hash_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, SHALL set the clock cycles per UART bit (100 MHz / 9600 baud); legal range is 2 or more.
REQ-002 Parameter DATA_W, default 512, SHALL set the width of the digest input bus.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 transmit  input  1: start request, level from the debouncer; only its rising edge is acted upon.
REQ-006 d  input  16: digest length in bits.
REQ-007 data  input  DATA_W: digest, right-aligned; bit 0 is the digest LSB.
REQ-008 TxD  output  1: UART serial line, 8N1, idle high.
REQ-009 busy  output  1: high from the first start bit through the last stop bit.
REQ-010 done  output  1: one-cycle pulse when a frame sequence completes.

Function
REQ-011 The block SHALL register transmit and SHALL detect a rising edge as transmit=1 with the previous sample=0.
REQ-012 A rising edge while idle SHALL latch data and d into internal registers in that cycle; input changes after the latch SHALL NOT affect the frames.
REQ-013 Byte count nbytes SHALL equal ceil(d/8), clamped to DATA_W/8 when d > DATA_W.
REQ-014 With d=0, the block SHALL send no frames, keep busy low, and pulse done one cycle after the edge.
REQ-015 Bytes SHALL be sent most-significant first: byte k (k=0..nbytes-1) = latched data[8*(nbytes-k)-1 -: 8]; the last byte sent is data[7:0].
REQ-016 Each frame SHALL be one start bit (0), eight data bits LSB first, and one stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-017 The state machine SHALL have the states IDLE, START, DATA, STOP and NEXT:
- IDLE to START on an accepted edge with nbytes > 0.
- START to DATA after one bit time.
- DATA to STOP after 8 bit times.
- STOP to NEXT after one bit time.
- NEXT to START if bytes remain, else to IDLE.
REQ-018 NEXT SHALL last exactly one cycle with TxD high; the inter-frame gap is therefore one stop bit plus one cycle.
REQ-019 Latency: TxD SHALL fall (start bit) two cycles after the cycle in which the raw transmit goes high, counting the synchroniser register.
REQ-020 A baud counter SHALL restart at 0 on every state entry, so bit timing never drifts across bytes.
REQ-021 A byte counter of width log2(DATA_W/8)+1 SHALL count sent bytes and SHALL NOT wrap.
REQ-022 Rising edges on transmit while busy SHALL be ignored, not queued; a level held high SHALL yield exactly one transmission.
REQ-023 An edge occurring in the same cycle as done SHALL be ignored; only an edge while in IDLE with done low starts a new sequence.
REQ-024 done SHALL pulse in the cycle NEXT returns to IDLE; busy SHALL fall in that same cycle.
REQ-025 TxD SHALL be driven from a register, glitch-free.

Reset
REQ-026 While reset=0, the block SHALL force, without waiting for a clock edge: TxD=1, busy=0, done=0, state=IDLE, all counters 0, latched registers 0 and the transmit edge register 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; after release, no partial frame SHALL resume.
REQ-028 A transmit level already high at reset release SHALL NOT start a transmission until it goes low and rises again.

Verification (CLKS_PER_BIT=4)
REQ-029 d=512, data=0x00..3F (byte i = i, counting from the LSB byte), one pulse -> 64 frames, first 0x3F, last 0x00, each frame 40 cycles, then a one-cycle done pulse.
REQ-030 d=20, data low bits 0xABCDE -> 3 frames 0x0A, 0xBC, 0xDE; bit order on TxD for 0x0A is 0,0,1,0,1,0,0,0,0,1.
REQ-031 d=0 -> TxD stays high, busy stays 0, done pulses once.
REQ-032 transmit held high for 1000 cycles with d=8 -> exactly one frame; a second pulse while busy -> no extra frames.
REQ-033 reset=0 in the middle of byte 2 of 3 -> TxD=1 in the same cycle, busy=0; a new pulse after release -> the full sequence restarts from byte 0.
REQ-034 d=600 -> clamped to 64 frames; changing data mid-sequence -> the transmitted bytes are unchanged.
